// File: rtl/rvh_pmp_checker.sv
// Physical memory protection checker: PMP CSR storage plus one access check per cycle.
// Latency: one cycle from request acceptance to resp_*; CSR readback is combinational.
// Backpressure: req_rdy_o = ~resp_vld_o | resp_rdy_i, so a stalled response holds the input; CSR writes are never stalled.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   csr_wr_vld_i/_is_cfg_i/_idx_i/_data_i  pmpcfg / pmpaddr write port
//   csr_rd_idx_i, csr_rd_addr_o, csr_rd_cfg_o  combinational readback
//   req_vld_i/req_rdy_o, req_paddr_i, req_size_i, req_access_type_i, req_priv_m_i  check request
//   resp_vld_o/resp_rdy_i, resp_fault_o, resp_hit_o, resp_hit_idx_o                check result
module rvh_pmp_checker #(
  parameter int PADDR_WIDTH = 56,
  parameter int ENTRY_COUNT = 16,
  localparam int IDX_W = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   csr_wr_vld_i,
  input  logic                   csr_wr_is_cfg_i,
  input  logic [IDX_W-1:0]       csr_wr_idx_i,
  input  logic [63:0]            csr_wr_data_i,
  input  logic [IDX_W-1:0]       csr_rd_idx_i,
  output logic [63:0]            csr_rd_addr_o,
  output logic [7:0]             csr_rd_cfg_o,
  input  logic                   req_vld_i,
  output logic                   req_rdy_o,
  input  logic [PADDR_WIDTH-1:0] req_paddr_i,
  input  logic [1:0]             req_size_i,
  input  logic [1:0]             req_access_type_i,
  input  logic                   req_priv_m_i,
  output logic                   resp_vld_o,
  input  logic                   resp_rdy_i,
  output logic                   resp_fault_o,
  output logic                   resp_hit_o,
  output logic [IDX_W-1:0]       resp_hit_idx_o
);

  localparam int AW = PADDR_WIDTH - 2;  // stored address bits (paddr[PADDR_WIDTH-1:2])
  localparam int W1 = PADDR_WIDTH + 1;  // one spare bit so range ends never wrap

  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  typedef struct packed {
    logic       l;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  logic [AW-1:0] addr_q [ENTRY_COUNT];
  pmp_cfg_t      cfg_q  [ENTRY_COUNT];

  // ---------------------------------------------------------------- CSR write
  pmp_cfg_t               wr_cfg;
  logic [ENTRY_COUNT-1:0] tor_locked_above;
  logic                   unused_wr_bits;

  // R=0/W=1 is a reserved combination; it is stored with W cleared.
  assign wr_cfg = '{l: csr_wr_data_i[7], a: csr_wr_data_i[4:3], x: csr_wr_data_i[2],
                    w: csr_wr_data_i[1] & csr_wr_data_i[0], r: csr_wr_data_i[0]};
  assign unused_wr_bits = ^csr_wr_data_i[63:AW];

  // A locked TOR entry also freezes the address of the entry below it (its base).
  always_comb begin
    tor_locked_above = '0;
    for (int i = 0; i < ENTRY_COUNT - 1; i++) begin
      tor_locked_above[i] = cfg_q[i+1].l && (cfg_q[i+1].a == A_TOR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        addr_q[i] <= '0;
        cfg_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        if (csr_wr_vld_i && (csr_wr_idx_i == IDX_W'(i)) && !cfg_q[i].l) begin
          if (csr_wr_is_cfg_i) begin
            cfg_q[i] <= wr_cfg;
          end else if (!tor_locked_above[i]) begin
            addr_q[i] <= csr_wr_data_i[AW-1:0];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- readback
  always_comb begin
    csr_rd_addr_o = '0;
    csr_rd_cfg_o  = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if (csr_rd_idx_i == IDX_W'(i)) begin
        csr_rd_addr_o = 64'(addr_q[i]);
        csr_rd_cfg_o  = {cfg_q[i].l, 2'b00, cfg_q[i].a, cfg_q[i].x, cfg_q[i].w, cfg_q[i].r};
      end
    end
  end

  // ---------------------------------------------------------------- range decode
  logic [AW-1:0] prev_addr [ENTRY_COUNT];
  logic [AW-1:0] nap_mask  [ENTRY_COUNT];
  logic [W1-1:0] ent_lo    [ENTRY_COUNT];
  logic [W1-1:0] ent_hi    [ENTRY_COUNT];  // exclusive bound
  logic          ent_en    [ENTRY_COUNT];

  always_comb begin
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      prev_addr[i] = (i == 0) ? '0 : addr_q[(i == 0) ? 0 : i - 1];
      // Low bits set up to and including the first zero: t trailing ones -> t+1 bits.
      nap_mask[i]  = addr_q[i] ^ (addr_q[i] + AW'(1));
      ent_lo[i]    = '0;
      ent_hi[i]    = '0;
      ent_en[i]    = 1'b0;
      case (cfg_q[i].a)
        A_TOR: begin
          ent_lo[i] = W1'({prev_addr[i], 2'b00});
          ent_hi[i] = W1'({addr_q[i], 2'b00});
          ent_en[i] = ent_lo[i] < ent_hi[i];
        end
        A_NA4: begin
          ent_lo[i] = W1'({addr_q[i], 2'b00});
          ent_hi[i] = ent_lo[i] + W1'(4);
          ent_en[i] = 1'b1;
        end
        A_NAPOT: begin
          ent_lo[i] = W1'({addr_q[i], 2'b00}) & ~W1'({nap_mask[i], 2'b11});
          ent_hi[i] = ent_lo[i] + W1'({nap_mask[i], 2'b11}) + W1'(1);
          ent_en[i] = 1'b1;
        end
        default: ent_en[i] = 1'b0;  // A_OFF
      endcase
    end
  end

  // ---------------------------------------------------------------- match + fault
  logic [W1-1:0] acc_lo, acc_hi;  // inclusive access byte range
  logic          hit_d, full_d, perm_d, fault_d;
  logic [IDX_W-1:0] hit_idx_d;
  pmp_cfg_t      sel_cfg;

  always_comb begin
    acc_lo    = W1'(req_paddr_i);
    acc_hi    = acc_lo + (W1'(1) << req_size_i) - W1'(1);
    hit_d     = 1'b0;
    full_d    = 1'b0;
    hit_idx_d = '0;
    sel_cfg   = '0;
    // Walk downward so the lowest-index touching entry is the last one kept.
    for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
      if (ent_en[i] && (acc_lo < ent_hi[i]) && (acc_hi >= ent_lo[i])) begin
        hit_d     = 1'b1;
        full_d    = (acc_lo >= ent_lo[i]) && (acc_hi < ent_hi[i]);
        hit_idx_d = IDX_W'(i);
        sel_cfg   = cfg_q[i];
      end
    end

    case (req_access_type_i)
      2'd0:    perm_d = sel_cfg.r;
      2'd1:    perm_d = sel_cfg.w;
      2'd2:    perm_d = sel_cfg.x;
      default: perm_d = 1'b0;
    endcase

    if (req_access_type_i == 2'd3)          fault_d = 1'b1;
    else if (hit_d && !full_d)              fault_d = 1'b1;
    else if (hit_d)                         fault_d = (req_priv_m_i && !sel_cfg.l) ? 1'b0 : !perm_d;
    else                                    fault_d = !req_priv_m_i;
  end

  // ---------------------------------------------------------------- response stage
  logic req_acc;

  assign req_rdy_o = !resp_vld_o || resp_rdy_i;
  assign req_acc   = req_vld_i && req_rdy_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_vld_o     <= 1'b0;
      resp_fault_o   <= 1'b0;
      resp_hit_o     <= 1'b0;
      resp_hit_idx_o <= '0;
    end else if (req_acc) begin
      resp_vld_o     <= 1'b1;
      resp_fault_o   <= fault_d;
      resp_hit_o     <= hit_d;
      resp_hit_idx_o <= hit_idx_d;
    end else if (resp_rdy_i) begin
      resp_vld_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rvh_pmp_checker.sv
// Directed bench for rvh_pmp_checker: CSR lock rules, NAPOT/TOR/NA4 matching,
// priority, same-cycle CSR/check ordering, backpressure and reset.
module tb_rvh_pmp_checker;

  localparam int PW = 56;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          csr_wr_vld_i, csr_wr_is_cfg_i;
  logic [IW-1:0] csr_wr_idx_i, csr_rd_idx_i;
  logic [63:0]   csr_wr_data_i, csr_rd_addr_o;
  logic [7:0]    csr_rd_cfg_o;
  logic          req_vld_i, req_rdy_o, req_priv_m_i;
  logic [PW-1:0] req_paddr_i;
  logic [1:0]    req_size_i, req_access_type_i;
  logic          resp_vld_o, resp_rdy_i, resp_fault_o, resp_hit_o;
  logic [IW-1:0] resp_hit_idx_o;

  int errors = 0;
  int checks = 0;

  rvh_pmp_checker dut (
    .clk(clk), .rst(rst),
    .csr_wr_vld_i(csr_wr_vld_i), .csr_wr_is_cfg_i(csr_wr_is_cfg_i),
    .csr_wr_idx_i(csr_wr_idx_i), .csr_wr_data_i(csr_wr_data_i),
    .csr_rd_idx_i(csr_rd_idx_i), .csr_rd_addr_o(csr_rd_addr_o), .csr_rd_cfg_o(csr_rd_cfg_o),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_paddr_i(req_paddr_i),
    .req_size_i(req_size_i), .req_access_type_i(req_access_type_i), .req_priv_m_i(req_priv_m_i),
    .resp_vld_o(resp_vld_o), .resp_rdy_i(resp_rdy_i), .resp_fault_o(resp_fault_o),
    .resp_hit_o(resp_hit_o), .resp_hit_idx_o(resp_hit_idx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic csr_wr(input logic is_cfg, input int idx, input logic [63:0] data);
    @(negedge clk);
    csr_wr_vld_i    = 1'b1;
    csr_wr_is_cfg_i = is_cfg;
    csr_wr_idx_i    = IW'(idx);
    csr_wr_data_i   = data;
    @(negedge clk);
    csr_wr_vld_i    = 1'b0;
  endtask

  task automatic chk_cfg(input string tag, input int idx, input logic [7:0] exp);
    csr_rd_idx_i = IW'(idx);
    #1;
    chk(tag, 64'(csr_rd_cfg_o), 64'(exp));
  endtask

  task automatic chk_addr(input string tag, input int idx, input logic [63:0] exp);
    csr_rd_idx_i = IW'(idx);
    #1;
    chk(tag, csr_rd_addr_o, exp);
  endtask

  // One request with resp_rdy_i high; result sampled on the following falling edge.
  task automatic do_req(input string tag, input logic [PW-1:0] pa, input logic [1:0] sz,
                        input logic [1:0] typ, input logic m,
                        input logic ef, input logic eh, input logic [IW-1:0] ei);
    @(negedge clk);
    req_vld_i = 1'b1; req_paddr_i = pa; req_size_i = sz;
    req_access_type_i = typ; req_priv_m_i = m; resp_rdy_i = 1'b1;
    @(negedge clk);
    chk({tag, ".vld"},   64'(resp_vld_o),     64'(1'b1));
    chk({tag, ".fault"}, 64'(resp_fault_o),   64'(ef));
    chk({tag, ".hit"},   64'(resp_hit_o),     64'(eh));
    chk({tag, ".idx"},   64'(resp_hit_idx_o), 64'(ei));
    req_vld_i = 1'b0;
  endtask

  // Backpressure stimulus table
  logic [PW-1:0] bp_pa [3] = '{56'h1FFC, 56'h100, 56'h8010};
  logic [1:0]    bp_sz [3] = '{2'd2, 2'd2, 2'd3};
  logic [1:0]    bp_ty [3] = '{2'd0, 2'd0, 2'd1};
  logic          bp_m  [3] = '{1'b0, 1'b0, 1'b1};
  logic          bp_f  [3] = '{1'b0, 1'b1, 1'b1};
  logic [IW-1:0] bp_i  [3] = '{4'd1, 4'd0, 4'd2};

  initial begin
    rst = 1'b1;
    csr_wr_vld_i = 1'b0; csr_wr_is_cfg_i = 1'b0; csr_wr_idx_i = '0; csr_wr_data_i = '0;
    csr_rd_idx_i = '0;
    req_vld_i = 1'b0; req_paddr_i = '0; req_size_i = '0; req_access_type_i = '0;
    req_priv_m_i = 1'b0; resp_rdy_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.vld",   64'(resp_vld_o),   64'(0));
    chk("rst.rdy",   64'(req_rdy_o),    64'(1));
    chk("rst.fault", 64'(resp_fault_o), 64'(0));
    chk_cfg("rst.cfg0", 0, 8'h00);
    chk_addr("rst.addr0", 0, 64'h0);

    // NAPOT lock: 8 KiB at 0x8000, L + R only
    csr_wr(1'b0, 2, 64'h23FF);
    csr_wr(1'b1, 2, 64'h99);
    chk_cfg("napot.cfg", 2, 8'h99);
    do_req("napot.mw", 56'h8010, 2'd3, 2'd1, 1'b1, 1'b1, 1'b1, 4'd2);
    do_req("napot.mr", 56'h8010, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 4'd2);
    csr_wr(1'b1, 2, 64'h00);
    chk_cfg("napot.lockcfg", 2, 8'h99);
    csr_wr(1'b0, 2, 64'h0);
    chk_addr("napot.lockaddr", 2, 64'h23FF);

    // TOR [0x1000, 0x2000) RW
    csr_wr(1'b0, 0, 64'h400);
    csr_wr(1'b0, 1, 64'h800);
    csr_wr(1'b1, 1, 64'h0B);
    chk_cfg("tor.cfg", 1, 8'h0B);
    do_req("tor.full",  56'h1FFC, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 4'd1);
    do_req("tor.part",  56'h1FFE, 2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 4'd1);
    do_req("tor.miss",  56'h2000, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    do_req("tor.resv",  56'h1000, 2'd0, 2'd3, 1'b1, 1'b1, 1'b1, 4'd1);

    // Priority: entry 0 NA4 @0x100 no perms, entry 3 NAPOT 8B @0x100 R
    csr_wr(1'b0, 0, 64'h40);
    csr_wr(1'b1, 0, 64'h10);
    csr_wr(1'b0, 3, 64'h40);
    csr_wr(1'b1, 3, 64'h19);
    do_req("prio.sr", 56'h100, 2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 4'd0);
    do_req("prio.mr", 56'h100, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 4'd0);

    // Same-cycle CSR write and check: the check sees the old entry 7
    csr_wr(1'b0, 7, 64'h1400);
    @(negedge clk);
    csr_wr_vld_i = 1'b1; csr_wr_is_cfg_i = 1'b1; csr_wr_idx_i = 4'd7; csr_wr_data_i = 64'h11;
    req_vld_i = 1'b1; req_paddr_i = 56'h5000; req_size_i = 2'd2;
    req_access_type_i = 2'd0; req_priv_m_i = 1'b0; resp_rdy_i = 1'b1;
    @(negedge clk);
    chk("same.hit",   64'(resp_hit_o),   64'(0));
    chk("same.fault", 64'(resp_fault_o), 64'(1));
    csr_wr_vld_i = 1'b0; req_vld_i = 1'b0;
    do_req("same.next", 56'h5000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 4'd7);

    // Backpressure: three back-to-back requests, consumer stalled two cycles
    begin
      int sent = 0;
      int got = 0;
      for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
        @(negedge clk);
        resp_rdy_i = (cyc >= 3);
        req_vld_i  = (sent < 3);
        if (sent < 3) begin
          req_paddr_i = bp_pa[sent]; req_size_i = bp_sz[sent];
          req_access_type_i = bp_ty[sent]; req_priv_m_i = bp_m[sent];
        end
        #1;
        if (cyc == 1 || cyc == 2) begin
          chk("bp.stall_rdy", 64'(req_rdy_o),     64'(0));
          chk("bp.stall_idx", 64'(resp_hit_idx_o), 64'(bp_i[0]));
        end
        if (resp_vld_o && resp_rdy_i) begin
          chk("bp.fault", 64'(resp_fault_o),   64'(bp_f[got]));
          chk("bp.idx",   64'(resp_hit_idx_o), 64'(bp_i[got]));
          got++;
        end
        if (req_vld_i && req_rdy_o) sent++;
      end
      chk("bp.count", 64'(got), 64'(3));
      req_vld_i = 1'b0;
      @(negedge clk);
      chk("bp.drain", 64'(resp_vld_o), 64'(0));
    end

    // Write-lock chain
    csr_wr(1'b0, 4, 64'h111);
    csr_wr(1'b0, 5, 64'h200);
    csr_wr(1'b1, 5, 64'h88);
    chk_cfg("lock.cfg5", 5, 8'h88);
    csr_wr(1'b0, 4, 64'h222);
    chk_addr("lock.addr4", 4, 64'h111);
    csr_wr(1'b1, 4, 64'h01);
    chk_cfg("lock.cfg4", 4, 8'h01);
    csr_wr(1'b1, 6, 64'h0A);
    chk_cfg("lock.wr0", 6, 8'h08);

    // Reset while a response is stalled
    @(negedge clk);
    req_vld_i = 1'b1; req_paddr_i = 56'h8010; req_size_i = 2'd3;
    req_access_type_i = 2'd1; req_priv_m_i = 1'b1; resp_rdy_i = 1'b0;
    @(negedge clk);
    req_vld_i = 1'b0;
    chk("rstm.pre_vld", 64'(resp_vld_o), 64'(1));
    chk("rstm.pre_hit", 64'(resp_hit_o), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstm.vld",   64'(resp_vld_o),     64'(0));
    chk("rstm.hit",   64'(resp_hit_o),     64'(0));
    chk("rstm.fault", 64'(resp_fault_o),   64'(0));
    chk("rstm.idx",   64'(resp_hit_idx_o), 64'(0));
    @(negedge clk);
    chk("rstm.rdy", 64'(req_rdy_o), 64'(1));
    for (int i = 0; i < 16; i++) chk_cfg("rstm.cfg", i, 8'h00);
    chk_addr("rstm.addr2", 2, 64'h0);
    do_req("rstm.after", 56'h8010, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
